final_exam_count_checker: RTL
=============================

Name: final_exam_count_checker

Overview:
- Downstream monitor for the final-exam up/down/loadable counter.
- Observes the counter's control inputs and its count output on the shared clk.
- Each cycle it predicts the next count and checks the observed count against it.
- Flags mismatches, counts them, and pulses on wrap-around; used as an in-line self-check in benches and on the board.

Parameters:
N, 3, counter width in bits; must match the counter instance
ECW, 8, width of the saturating mismatch counter

Ports:
clk  input  1  system clock, rising edge
r  input  1  synchronous active-high reset, shared with the counter
e  input  1  counter enable, same signal the counter sees
load  input  1  counter load strobe, same signal the counter sees
updown  input  1  direction: 1 = up, 0 = down
ld_val  input  N  value the counter loads when load=1
count  input  N  observed counter output
trk  output  1  1 when the checker holds a valid prediction (TRACK state)
exp  output  N  predicted count for the current cycle
mism  output  1  one-cycle pulse: observed count differed from exp
fail  output  1  sticky: at least one mismatch since reset
mism_cnt  output  ECW  number of mismatches, saturating at all-ones
wrap_up  output  1  one-cycle pulse: verified transition all-ones -> 0 while counting up
wrap_dn  output  1  one-cycle pulse: verified transition 0 -> all-ones while counting down
fail_exp  output  N  exp value at the first mismatch
fail_got  output  N  count value at the first mismatch

Behaviour:
- Clock and reset: single clock clk. Reset r is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: trk=0, exp=0, mism=0, fail=0, mism_cnt=0, wrap_up=0, wrap_dn=0, fail_exp=0, fail_got=0.
- Reset behaves identically at any time, including mid-sequence. It has priority over all other activity.
- Next-value function nxt(c), evaluated on controls sampled at a posedge:
  - if load: ld_val;
  - else if e and updown: (c+1) mod 2^N;
  - else if e and not updown: (c-1) mod 2^N;
  - else: c.
  - load has priority over e.
- States are IDLE and TRACK, shown on trk.
- IDLE:
  - Entered on reset.
  - First posedge with r=0: exp <= nxt(count), then go to TRACK.
  - No checking, no wrap pulses, mism=0.
- TRACK, at each posedge with r=0, compare count with exp:
  - Match:
    - exp <= nxt(count).
    - wrap_up <= (exp==0 and previous-cycle controls were count-up from all-ones).
    - wrap_dn <= (exp==all-ones and previous-cycle controls were count-down from 0).
    - A load of 0 or all-ones never produces a wrap pulse.
  - Mismatch:
    - mism <= 1 for exactly one cycle.
    - mism_cnt <= mism_cnt+1, saturating.
    - fail <= 1, sticky.
    - Resynchronise: exp <= nxt(count), so one fault is reported once, not every following cycle.
  - Stay in TRACK until reset.
- Latency: a wrong count visible during cycle k is reported on mism in cycle k+1, i.e. one clk after the posedge that samples it.
- Controls e, load, updown, ld_val are registered together with count every cycle. Wrap qualification uses only these registered copies.
- mism and a wrap pulse are never high in the same cycle.
- Arithmetic is modulo 2^N. No sign interpretation.

Optional Feature:
- Macro: FINAL_EXAM_CHK_CAPTURE_EN.
- Defined:
  - On the first mismatch after reset, fail_exp <= exp and fail_got <= count.
  - Later mismatches do not overwrite them; they hold until reset.
- Not defined:
  - fail_exp and fail_got are tied to 0.
  - No capture registers are built.
  - All other behaviour is unchanged.

Test Plan:
- Reset then count up (N=3): r=1 for 2 cycles, then e=1, updown=1, load=0, counter 0..7..0.
  - trk=1 from the 2nd cycle after reset release.
  - mism never asserts.
  - wrap_up pulses once, the cycle after count shows 0 following 7.
- Count down with wrap: updown=0 from count=2, observed 2,1,0,7,6.
  - wrap_dn pulses once, one cycle after 7 is observed.
  - fail stays 0.
- Load priority: at count=3 apply load=1, e=1, updown=1, ld_val=6.
  - exp=6 in the next cycle; count 6 accepted with no mism.
  - With e=0 and load=0, exp holds.
- Injected fault: the bench forces count=5 when exp=2.
  - mism=1 for one cycle; mism_cnt=1; fail=1.
  - Next cycle exp=nxt(5) with no further mism.
  - With FINAL_EXAM_CHK_CAPTURE_EN: fail_exp=2, fail_got=5.
- Saturation: with ECW=2, inject 5 separate faults.
  - mism_cnt=3 and holds.
  - With FINAL_EXAM_CHK_CAPTURE_EN: fail_exp and fail_got still hold the first fault's values.
- Mid-run reset: assert r=1 for 1 cycle while fail=1 and in TRACK.
  - All outputs return to 0 and trk=0.
  - Tracking resumes one cycle after r falls.

Source files
------------

// File: rtl/final_exam_count_checker_if.sv
// Bundle of counter-side observation signals and checker results.
// master: the side that drives the counter controls and observed count.
// slave:  the checker, which consumes them and returns its verdicts.
interface final_exam_count_checker_if #(
    parameter int unsigned N   = 3,
    parameter int unsigned ECW = 8
);
    logic           e;
    logic           load;
    logic           updown;
    logic [N-1:0]   ld_val;
    logic [N-1:0]   count;
    logic           trk;
    logic [N-1:0]   exp;
    logic           mism;
    logic           fail;
    logic [ECW-1:0] mism_cnt;
    logic           wrap_up;
    logic           wrap_dn;
    logic [N-1:0]   fail_exp;
    logic [N-1:0]   fail_got;

    modport master (
        output e, load, updown, ld_val, count,
        input  trk, exp, mism, fail, mism_cnt, wrap_up, wrap_dn, fail_exp, fail_got
    );

    modport slave (
        input  e, load, updown, ld_val, count,
        output trk, exp, mism, fail, mism_cnt, wrap_up, wrap_dn, fail_exp, fail_got
    );
endinterface

// File: rtl/final_exam_count_checker.sv
// In-line checker for the up/down/loadable counter: predicts the next count,
// flags and counts mismatches, and pulses on verified wrap-around.
// Optional macro FINAL_EXAM_CHK_CAPTURE_EN builds first-mismatch capture
// registers for fail_exp/fail_got; without it both outputs are tied to 0.
module final_exam_count_checker #(
    parameter int unsigned N   = 3,
    parameter int unsigned ECW = 8
) (
    input logic                         clk,
    input logic                         r,
    final_exam_count_checker_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StTrack} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   exp_q, exp_d;
    logic           mism_q, mism_d;
    logic           fail_q, fail_d;
    logic [ECW-1:0] mism_cnt_q, mism_cnt_d;
    logic           wrap_up_q, wrap_up_d;
    logic           wrap_dn_q, wrap_dn_d;
    // Previous-cycle copies of controls and count used to qualify wraps
    logic           e_q, load_q, updown_q;
    logic [N-1:0]   cnt_q;
    logic [N-1:0]   nxt_val;
    logic           match;

    // Next-value of the counter from the current controls; load beats enable
    always_comb begin
        nxt_val = bus.count;
        if (bus.load) begin
            nxt_val = bus.ld_val;
        end else if (bus.e && bus.updown) begin
            nxt_val = bus.count + N'(1);
        end else if (bus.e) begin
            nxt_val = bus.count - N'(1);
        end
    end

    assign match = (bus.count == exp_q);

    // State, prediction, mismatch accounting and wrap qualification
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        mism_d     = 1'b0;
        fail_d     = fail_q;
        mism_cnt_d = mism_cnt_q;
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                exp_d   = nxt_val;
                state_d = StTrack;
            end
            StTrack: begin
                // Predict from the observed count either way, so a fault is reported once
                exp_d = nxt_val;
                if (!match) begin
                    mism_d = 1'b1;
                    fail_d = 1'b1;
                    if (mism_cnt_q != '1) begin
                        mism_cnt_d = mism_cnt_q + ECW'(1);
                    end
                end else begin
                    wrap_up_d = (exp_q == '0) && !load_q && e_q && updown_q && (cnt_q == '1);
                    wrap_dn_d = (exp_q == '1) && !load_q && e_q && !updown_q && (cnt_q == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Main registers with synchronous reset
    always_ff @(posedge clk) begin
        if (r) begin
            state_q    <= StIdle;
            exp_q      <= '0;
            mism_q     <= 1'b0;
            fail_q     <= 1'b0;
            mism_cnt_q <= '0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            e_q        <= 1'b0;
            load_q     <= 1'b0;
            updown_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            mism_q     <= mism_d;
            fail_q     <= fail_d;
            mism_cnt_q <= mism_cnt_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            e_q        <= bus.e;
            load_q     <= bus.load;
            updown_q   <= bus.updown;
            cnt_q      <= bus.count;
        end
    end

`ifdef FINAL_EXAM_CHK_CAPTURE_EN
    logic [N-1:0] fail_exp_q, fail_exp_d;
    logic [N-1:0] fail_got_q, fail_got_d;

    // Capture prediction and observation only on the first mismatch since reset
    always_comb begin
        fail_exp_d = fail_exp_q;
        fail_got_d = fail_got_q;
        if ((state_q == StTrack) && !match && !fail_q) begin
            fail_exp_d = exp_q;
            fail_got_d = bus.count;
        end
    end

    // Capture registers
    always_ff @(posedge clk) begin
        if (r) begin
            fail_exp_q <= '0;
            fail_got_q <= '0;
        end else begin
            fail_exp_q <= fail_exp_d;
            fail_got_q <= fail_got_d;
        end
    end

    assign bus.fail_exp = fail_exp_q;
    assign bus.fail_got = fail_got_q;
`else
    assign bus.fail_exp = '0;
    assign bus.fail_got = '0;
`endif

    assign bus.trk      = (state_q == StTrack);
    assign bus.exp      = exp_q;
    assign bus.mism     = mism_q;
    assign bus.fail     = fail_q;
    assign bus.mism_cnt = mism_cnt_q;
    assign bus.wrap_up  = wrap_up_q;
    assign bus.wrap_dn  = wrap_dn_q;

endmodule
